// File: rtl/cache_mem_arbiter.sv
// Shares one 32-bit memory port between I-cache and D-cache: 4-beat line refills and single-beat stores.
// Optional ARB_ROUND_ROBIN_EN: alternate I vs D on simultaneous requests instead of fixed D > I priority.
module cache_mem_arbiter #(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 imiss,
  input  logic [ADDR_W-1:0]    iaddr,
  input  logic                 dmiss,
  input  logic [ADDR_W-1:0]    daddr,
  input  logic                 dwrite,
  input  logic [31:0]          dwdata,
  output logic [32*BEATS-1:0]  linedata,
  output logic                 ireadready,
  output logic                 dreadready,
  output logic                 dwdone,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_BURST, S_WR, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_DR, OWN_DW} owner_t;

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_W-1:OFF_W]   areg_q, areg_d;
  logic [32*BEATS-1:0]     linedata_q, linedata_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    ireadready_q, ireadready_d;
  logic                    dreadready_q, dreadready_d;
  logic                    dwdone_q, dwdone_d;
  logic                    grant_dcls;

  // Line offset bits of the request addresses are implied by the burst/word sequencing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[OFF_W-1:0], daddr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dgrant_q, last_dgrant_d;
  // On an I-vs-D conflict the class that was not granted last wins.
  assign grant_dcls = (dmiss | dwrite) & (~imiss | ~last_dgrant_q);
`else
  assign grant_dcls = dmiss | dwrite;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    beat_d       = beat_q;
    areg_d       = areg_q;
    linedata_d   = linedata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ireadready_d = 1'b0;
    dreadready_d = 1'b0;
    dwdone_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_dgrant_d = last_dgrant_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        if (grant_dcls) begin
          areg_d = daddr[ADDR_W-1:OFF_W];
`ifdef ARB_ROUND_ROBIN_EN
          last_dgrant_d = 1'b1;
`endif
          if (dmiss) begin
            owner_d    = OWN_DR;
            state_d    = S_RD_BURST;
            beat_d     = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {daddr[ADDR_W-1:OFF_W], {BEAT_W{1'b0}}, 2'b00};
          end else begin
            // Store data and address settle on the bus for one cycle before mem_req rises.
            owner_d     = OWN_DW;
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = {daddr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = dwdata;
          end
        end else if (imiss) begin
          areg_d     = iaddr[ADDR_W-1:OFF_W];
          owner_d    = OWN_I;
          state_d    = S_RD_BURST;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {iaddr[ADDR_W-1:OFF_W], {BEAT_W{1'b0}}, 2'b00};
`ifdef ARB_ROUND_ROBIN_EN
          last_dgrant_d = 1'b0;
`endif
        end
      end

      S_RD_BURST: begin
        if (mem_ack) begin
          linedata_d[32*beat_q +: 32] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d      = S_DONE;
            mem_req_d    = 1'b0;
            ireadready_d = (owner_q == OWN_I);
            dreadready_d = (owner_q == OWN_DR);
          end else begin
            mem_addr_d = {areg_q, beat_d, 2'b00};
          end
        end
      end

      S_WR: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          dwdone_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      beat_q       <= '0;
      areg_q       <= '0;
      linedata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ireadready_q <= 1'b0;
      dreadready_q <= 1'b0;
      dwdone_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beat_q       <= beat_d;
      areg_q       <= areg_d;
      linedata_q   <= linedata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ireadready_q <= ireadready_d;
      dreadready_q <= dreadready_d;
      dwdone_q     <= dwdone_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) last_dgrant_q <= 1'b0;
    else     last_dgrant_q <= last_dgrant_d;
  end
`endif

  assign linedata   = linedata_q;
  assign ireadready = ireadready_q;
  assign dreadready = dreadready_q;
  assign dwdone     = dwdone_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed cases plus randomized request mixes
// checked against a transaction-level model of arbitration order, beat addresses and lines.
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         imiss = 1'b0, dmiss = 1'b0, dwrite = 1'b0;
  logic [31:0]  iaddr = '0, daddr = '0, dwdata = '0;
  logic [127:0] linedata;
  logic         ireadready, dreadready, dwdone;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  cache_mem_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .imiss(imiss), .iaddr(iaddr),
    .dmiss(dmiss), .daddr(daddr),
    .dwrite(dwrite), .dwdata(dwdata),
    .linedata(linedata),
    .ireadready(ireadready), .dreadready(dreadready), .dwdone(dwdone),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  // Memory contents: the 0x123x line holds 0xA0..0xA3, everything else a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'h000000A0 + {30'd0, a[3:2]};
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  function automatic logic [127:0] exp_line(input logic [31:0] a);
    logic [127:0] l;
    l = '0;
    for (int b = 0; b < 4; b++) l[32*b +: 32] = mem_word({a[31:4], 2'(b), 2'b00});
    return l;
  endfunction

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic ack; } req_t;
  typedef struct { int kind; logic [127:0] line; } done_t;   // kind: 0=I refill, 1=D refill, 2=store
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;

  req_t  req_log[$];
  done_t done_log[$];
  int    pulse_bad = 0;

  int          errors = 0;
  int          checks = 0;
  int          ack_mode = 0;      // 0: tied high, 1: random, 2: pattern
  logic [15:0] ack_pat = '0;
  int          ack_len = 0;
  int          pat_gen = 0;
  bit          last_d = 1'b0;     // model: D class granted last

  // Memory ack driver: new value just after each rising edge.
  initial begin
    int idx;
    int seen_gen;
    idx = 0;
    seen_gen = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (pat_gen != seen_gen) begin
        seen_gen = pat_gen;
        idx = 0;
      end
      if (ack_mode == 0) mem_ack = 1'b1;
      else if (ack_mode == 1) mem_ack = 1'($urandom_range(0, 1));
      else if (mem_req && idx < ack_len) begin
        mem_ack = ack_pat[idx[3:0]];
        idx++;
      end else mem_ack = 1'b0;
    end
  end

  // Bus monitor: logs every requesting cycle and every completion pulse.
  initial begin
    int kd;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (mem_req) req_log.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata, ack: mem_ack});
        if (ireadready || dreadready || dwdone) begin
          if ((int'(ireadready) + int'(dreadready) + int'(dwdone)) != 1 || mem_req) pulse_bad++;
          kd = ireadready ? 0 : (dreadready ? 1 : 2);
          done_log.push_back('{kind: kd, line: linedata});
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input string tag);
    #2;
    Rst = 1'b1;
    imiss = 1'b0;
    dmiss = 1'b0;
    dwrite = 1'b0;
    #1;
    check({tag, "_line"}, linedata, '0);
    check({tag, "_outs"}, 128'({ireadready, dreadready, dwdone, mem_req, mem_we, mem_addr, mem_wdata}), '0);
    last_d = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic set_pattern(input logic [15:0] bits, input int len);
    ack_pat = bits;
    ack_len = len;
    pat_gen++;
    ack_mode = 2;
  endtask

  // Raise a request mix, let the requesters drop on their pulse, then compare against the model.
  task automatic issue(input bit ri, input bit rdr, input bit rdw,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       output int lat);
    beat_t eb[$];
    done_t ed[$];
    bit    pi, pdr, pdw, take_d;
    int    rbase, dbase, bbase, n, k, extra;
    logic [31:0] a;
    pi = ri; pdr = rdr; pdw = rdw;
    rbase = req_log.size();
    dbase = done_log.size();
    bbase = pulse_bad;
    n = 0; k = 0; extra = 0;

    while (pi || pdr || pdw) begin
      if (pi && (pdr || pdw)) take_d = RR_EN ? !last_d : 1'b1;
      else take_d = pdr || pdw;
      if (take_d && pdr) begin
        a = da; pdr = 1'b0; last_d = 1'b1;
        for (int b = 0; b < 4; b++) eb.push_back('{1'b0, {a[31:4], 2'(b), 2'b00}, 32'h0});
        ed.push_back('{1, exp_line(a)});
      end else if (take_d) begin
        pdw = 1'b0; last_d = 1'b1;
        eb.push_back('{1'b1, {da[31:2], 2'b00}, wd});
        ed.push_back('{2, 128'h0});
      end else begin
        a = ia; pi = 1'b0; last_d = 1'b0;
        for (int b = 0; b < 4; b++) eb.push_back('{1'b0, {a[31:4], 2'(b), 2'b00}, 32'h0});
        ed.push_back('{0, exp_line(a)});
      end
    end

    iaddr = ia; daddr = da; dwdata = wd;
    imiss = ri; dmiss = rdr; dwrite = rdw;
    lat = -1;
    while ((imiss || dmiss || dwrite) && n < 400) begin
      @(negedge Clk);
      n++;
      if ((ireadready || dreadready || dwdone) && lat < 0) lat = n;
      if (ireadready) imiss = 1'b0;
      if (dreadready) dmiss = 1'b0;
      if (dwdone) dwrite = 1'b0;
    end
    check("pending_after_budget", 128'({imiss, dmiss, dwrite}), '0);
    imiss = 1'b0; dmiss = 1'b0; dwrite = 1'b0;
    repeat (3) @(negedge Clk);

    check("done_count", 128'(done_log.size() - dbase), 128'(ed.size()));
    for (int i = 0; i < ed.size() && dbase + i < done_log.size(); i++) begin
      check($sformatf("done_kind[%0d]", i), 128'(done_log[dbase+i].kind), 128'(ed[i].kind));
      if (ed[i].kind != 2) check($sformatf("line[%0d]", i), done_log[dbase+i].line, ed[i].line);
    end
    for (int j = rbase; j < req_log.size(); j++) begin
      if (k < eb.size())
        check($sformatf("bus_cycle_beat%0d", k),
              128'({req_log[j].we, req_log[j].addr, req_log[j].we ? req_log[j].wdata : 32'h0}),
              128'({eb[k].we, eb[k].addr, eb[k].wdata}));
      else extra++;
      if (req_log[j].ack) k++;
    end
    check("beats_accepted", 128'(k), 128'(eb.size()));
    check("bus_cycles_after_last", 128'(extra), '0);
    check("pulse_protocol", 128'(pulse_bad - bbase), '0);
  endtask

  initial begin
    int lat;
    int d0;
    int r0;
    int n;
    int combo;

    @(negedge Clk);
    apply_reset("reset");

    // Basic I refill, ack tied high.
    ack_mode = 0;
    issue(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, lat);
    check("irefill_latency", 128'(lat), 128'(5));
    if (done_log.size() > 0)
      check("irefill_line_const", done_log[done_log.size()-1].line,
            128'h000000A3_000000A2_000000A1_000000A0);

    // Store with ack delayed three cycles.
    set_pattern(16'b1000, 4);
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0044, 32'hDEADBEEF, lat);
    check("store_delayed_latency", 128'(lat), 128'(6));

    // Store with ack tied high.
    ack_mode = 0;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0102, 32'h1234_5678, lat);
    check("store_latency", 128'(lat), 128'(3));

    // D grant, then an I/D conflict.
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_2000, 32'h0, lat);
    d0 = done_log.size();
    issue(1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_4008, 32'h0, lat);
    if (done_log.size() > d0)
      check("conflict_first_owner", 128'(done_log[d0].kind), RR_EN ? 128'(0) : 128'(1));

    // dmiss and dwrite together: refill before store.
    issue(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_7010, 32'hCAFE_F00D, lat);

    // Asynchronous reset after beat 1 of a refill, then the refill again.
    r0 = req_log.size();
    n = 0;
    iaddr = 32'h0000_5550;
    imiss = 1'b1;
    while (req_log.size() - r0 < 3 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("midburst_reached", 128'(req_log.size() - r0), 128'(3));
    apply_reset("async_reset");
    issue(1'b1, 1'b0, 1'b0, 32'h0000_5550, 32'h0, 32'h0, lat);
    check("refill_after_reset_latency", 128'(lat), 128'(5));

    // Ack pattern 1,0,0,1,0,1,1 over a refill.
    set_pattern(16'b0000_0000_0110_1001, 7);
    r0 = req_log.size();
    issue(1'b1, 1'b0, 1'b0, 32'h0000_1238, 32'h0, 32'h0, lat);
    check("pattern_bus_cycles", 128'(req_log.size() - r0), 128'(7));

    // Random request mixes with tied or random acks.
    for (int t = 0; t < 20; t++) begin
      combo = $urandom_range(1, 7);
      ack_mode = $urandom_range(0, 1);
      issue(combo[0], combo[1], combo[2], $urandom, $urandom, $urandom, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
